// File: rtl/softmax_sub_scheduler.sv
// softmax_sub_scheduler: per-vector sequencer for the softmax subtract stage
// (clear, gated downscale load, Ln wait with timeout, backpressured drain).
module softmax_sub_scheduler #(
    parameter int CNT_MAX    = 8,
    parameter int ADDR_WIDTH = $clog2(CNT_MAX),
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   vec_len_i,
    input  logic                  ds_valid_i,
    input  logic                  ds_last_i,
    input  logic                  ln_valid_i,
    input  logic                  sub_valid_i,
    input  logic                  sub_last_i,
    input  logic                  out_ready_i,
    output logic                  ds_en_o,
    output logic                  ln_en_o,
    output logic                  sub_clr_o,
    output logic                  sub_ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [2:0]            err_code_o
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WAIT_LN, DRAIN, DONE, ERR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   len_q, len_d;
    logic [CW-1:0]   ds_cnt_q, ds_cnt_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic [2:0]      code_q, code_d;
    logic            len_ok, hs, to_hit;

    assign len_ok = (vec_len_i != '0) && (vec_len_i <= CW'(CNT_MAX));
    assign hs     = sub_valid_i & out_ready_i;
    assign to_hit = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            ds_cnt_q  <= '0;
            out_cnt_q <= '0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
            code_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ds_cnt_q  <= ds_cnt_d;
            out_cnt_q <= out_cnt_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ds_cnt_d  = ds_cnt_q;
        out_cnt_d = out_cnt_q;
        to_cnt_d  = '0;
        err_d     = err_q;
        code_d    = code_q;
        case (state_q)
            IDLE: begin
                if (start_i && len_ok) begin
                    len_d   = vec_len_i;
                    err_d   = 1'b0;
                    code_d  = 3'd0;
                    state_d = CLEAR;
                end else if (start_i) begin
                    err_d  = 1'b1;
                    code_d = 3'd1;
                end
            end
            CLEAR: begin
                ds_cnt_d  = '0;
                out_cnt_d = '0;
                state_d   = LOAD;
            end
            LOAD: begin
                // An Ln result arriving before the buffer is full outranks a bad last marker
                if (ln_valid_i) begin
                    err_d   = 1'b1;
                    code_d  = 3'd4;
                    state_d = ERR;
                end else if (ds_valid_i && ds_cnt_q == len_q - CW'(1)) begin
                    state_d = WAIT_LN;
                end else if (ds_valid_i && ds_last_i) begin
                    err_d   = 1'b1;
                    code_d  = 3'd2;
                    state_d = ERR;
                end else if (ds_valid_i) begin
                    ds_cnt_d = ds_cnt_q + CW'(1);
                end
            end
            WAIT_LN: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (ln_valid_i) begin
                    state_d = DRAIN;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    code_d  = 3'd3;
                    state_d = ERR;
                end
            end
            DRAIN: begin
                if (hs && out_cnt_q == len_q - CW'(1)) begin
                    state_d = DONE;
                end else if (hs && sub_last_i) begin
                    err_d   = 1'b1;
                    code_d  = 3'd5;
                    state_d = ERR;
                end else if (hs) begin
                    out_cnt_d = out_cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ds_en_o     = state_q == LOAD;
    assign ln_en_o     = state_q == WAIT_LN;
    assign sub_clr_o   = (state_q == CLEAR) || (state_q == ERR);
    assign sub_ready_o = (state_q == DRAIN) & out_ready_i;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
endmodule

// File: tb/tb_softmax_sub_scheduler.sv
// tb_softmax_sub_scheduler: directed, table-driven bench for softmax_sub_scheduler
// (TIMEOUT=16 so the Ln timeout is reachable quickly).
module tb_softmax_sub_scheduler;
    logic       clk, rst;
    logic       start_i;
    logic [3:0] vec_len_i;
    logic       ds_valid_i, ds_last_i, ln_valid_i, sub_valid_i, sub_last_i, out_ready_i;
    logic       ds_en_o, ln_en_o, sub_clr_o, sub_ready_o, busy_o, done_o, err_o;
    logic [2:0] err_code_o;

    int errors = 0;
    int checks = 0;

    softmax_sub_scheduler #(.CNT_MAX(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .vec_len_i(vec_len_i),
        .ds_valid_i(ds_valid_i), .ds_last_i(ds_last_i), .ln_valid_i(ln_valid_i),
        .sub_valid_i(sub_valid_i), .sub_last_i(sub_last_i), .out_ready_i(out_ready_i),
        .ds_en_o(ds_en_o), .ln_en_o(ln_en_o), .sub_clr_o(sub_clr_o), .sub_ready_o(sub_ready_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] len;
        bit         bp;
        int         ln_dly;
        int         exp_cyc;
    } run_t;

    typedef struct {
        logic [3:0] len;
        logic [2:0] exp_code;
    } bad_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] len);
        start_i   = 1'b1;
        vec_len_i = len;
        tick;
        start_i   = 1'b0;
    endtask

    task automatic run(input run_t r);
        int cyc, hs, bad;
        start(r.len);
        out_ready_i = 1'b1;
        #1;
        chk("clr at T+1", {28'd0, sub_clr_o, busy_o, err_o, sub_ready_o}, 32'b1100);
        tick;
        chk("ds_en at T+2", {30'd0, ds_en_o, sub_clr_o}, 32'b10);
        for (int i = 0; i < int'(r.len); i++) begin
            ds_valid_i = 1'b1;
            ds_last_i  = (i == int'(r.len) - 1);
            tick;
        end
        ds_valid_i = 1'b0;
        ds_last_i  = 1'b0;
        chk("wait_ln enables", {30'd0, ln_en_o, ds_en_o}, 32'b10);
        repeat (r.ln_dly) tick;
        ln_valid_i = 1'b1;
        tick;
        ln_valid_i = 1'b0;
        chk("ln_en drops", {31'd0, ln_en_o}, 32'd0);
        cyc = 0;
        hs  = 0;
        bad = 0;
        while (!done_o && cyc < 100) begin
            out_ready_i = r.bp ? (cyc % 2 == 0) : 1'b1;
            sub_valid_i = 1'b1;
            sub_last_i  = (hs == int'(r.len) - 1);
            #1;
            if (sub_ready_o !== out_ready_i) bad++;
            if (sub_ready_o) hs++;
            tick;
            cyc++;
        end
        sub_valid_i = 1'b0;
        sub_last_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("drain cycles to done", cyc, r.exp_cyc);
        chk("handshakes", hs, {28'd0, r.len});
        chk("sub_ready mirror", bad, 0);
        chk("done pulse", {30'd0, done_o, err_o}, 32'b10);
        tick;
        chk("after done", {30'd0, done_o, busy_o}, 32'd0);
    endtask

    run_t runs[5];
    bad_t bads[3];

    initial begin
        runs[0] = '{len: 4'd8, bp: 1'b0, ln_dly: 3, exp_cyc: 8};
        runs[1] = '{len: 4'd8, bp: 1'b1, ln_dly: 2, exp_cyc: 15};
        runs[2] = '{len: 4'd1, bp: 1'b0, ln_dly: 0, exp_cyc: 1};
        runs[3] = '{len: 4'd4, bp: 1'b1, ln_dly: 1, exp_cyc: 7};
        runs[4] = '{len: 4'd5, bp: 1'b0, ln_dly: 5, exp_cyc: 5};
        bads[0] = '{len: 4'd0,  exp_code: 3'd1};
        bads[1] = '{len: 4'd9,  exp_code: 3'd1};
        bads[2] = '{len: 4'd15, exp_code: 3'd1};
        {start_i, ds_valid_i, ds_last_i, ln_valid_i, sub_valid_i, sub_last_i, out_ready_i} = '0;
        vec_len_i = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset outputs", {21'd0, ds_en_o, ln_en_o, sub_clr_o, sub_ready_o, busy_o, done_o, err_o, err_code_o}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        tick;

        for (int i = 0; i < 5; i++) run(runs[i]);

        for (int i = 0; i < 3; i++) begin
            start(bads[i].len);
            chk("bad len", {27'd0, busy_o, err_o, err_code_o}, {27'd0, 1'b0, 1'b1, bads[i].exp_code});
            tick;
            chk("bad len stays idle", {31'd0, busy_o}, 32'd0);
        end
        run('{len: 4'd4, bp: 1'b0, ln_dly: 1, exp_cyc: 4});

        start(4'd5);
        tick;
        for (int i = 0; i < 3; i++) begin
            ds_valid_i = 1'b1;
            ds_last_i  = (i == 2);
            tick;
        end
        ds_valid_i = 1'b0;
        ds_last_i  = 1'b0;
        chk("early ds_last", {26'd0, sub_clr_o, busy_o, err_o, err_code_o}, {26'd0, 3'b111, 3'd2});
        tick;
        chk("early ds_last idle", {26'd0, sub_clr_o, busy_o, err_o, err_code_o}, {26'd0, 3'b001, 3'd2});

        start(4'd2);
        tick;
        ds_valid_i = 1'b1;
        tick;
        tick;
        ds_valid_i = 1'b0;
        repeat (15) tick;
        chk("no timeout at 15", {30'd0, ln_en_o, err_o}, 32'b10);
        tick;
        chk("timeout at 16", {26'd0, sub_clr_o, ln_en_o, err_o, err_code_o}, {26'd0, 3'b101, 3'd3});
        tick;
        chk("timeout idle", {31'd0, busy_o}, 32'd0);

        start(4'd4);
        tick;
        ds_valid_i = 1'b1;
        ds_last_i  = 1'b1;
        ln_valid_i = 1'b1;
        tick;
        {ds_valid_i, ds_last_i, ln_valid_i} = '0;
        chk("ln in load", {28'd0, err_o, err_code_o}, {28'd0, 1'b1, 3'd4});
        tick;

        start(4'd2);
        tick;
        ds_valid_i = 1'b1;
        tick;
        tick;
        ds_valid_i = 1'b0;
        ln_valid_i = 1'b1;
        tick;
        ln_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        #1;
        chk("in drain", {30'd0, sub_ready_o, busy_o}, 32'b11);
        rst = 1'b1;
        #1;
        chk("async reset", {21'd0, ds_en_o, ln_en_o, sub_clr_o, sub_ready_o, busy_o, done_o, err_o, err_code_o}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready_i = 1'b0;
        tick;
        run('{len: 4'd2, bp: 1'b0, ln_dly: 0, exp_cyc: 2});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
